// File: rtl/p2s_arb_pkg.sv
// ----------------------------------------------------------------------------
// p2s_arb_pkg
//
// Shared types and helpers for the p2s_arbiter slice.
//   arb_state_t : arbiter FSM state (IDLE = choosing a requester,
//                 LOCKED = one requester owns the serializer until its
//                 last word is accepted or it times out)
//   CNT_W       : width of the word counter and of the idle-timeout counter
//   gid_w()     : width of an encoded requester index, never below 1 bit
// ----------------------------------------------------------------------------
package p2s_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int CNT_W = 16;

    // Width of an encoded requester index: max(1, $clog2(r)).
    function automatic int gid_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin picker. Starting at index ptr and
// searching upward with wrap-around, the first set bit of req wins.
// Holds no state: the caller owns ptr and decides when to advance it,
// so the same block can front any shared resource.
//
// Ports:
//   req       in  [R-1:0]   request vector
//   ptr       in  [GW-1:0]  highest-priority index this cycle (0..R-1)
//   grant     out [R-1:0]   one-hot winner, all zero when req is zero
//   grant_idx out [GW-1:0]  encoded winner, 0 when req is zero
//   any       out           at least one request is present
// ----------------------------------------------------------------------------
module rr_arbiter
    import p2s_arb_pkg::*;
#(
    parameter int  R  = 3,
    localparam int GW = gid_w(R)
) (
    input  logic [R-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [R-1:0]  grant,
    output logic [GW-1:0] grant_idx,
    output logic          any
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int i = 0; i < R; i++) begin
            // Candidate i positions after ptr, wrapped into 0..R-1.
            idx = int'(ptr) + i;
            if (idx >= R) begin
                idx = idx - R;
            end
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/p2s_arbiter.sv
// ----------------------------------------------------------------------------
// p2s_arbiter
//
// Shares one p2s serializer between R parallel-word requesters. A grant is
// held for a whole packet (until the word flagged req_last is accepted) so
// multi-word messages never interleave. The word toward the serializer is
// registered; a granted requester that goes quiet mid-packet for TIMEOUT
// consecutive cycles loses its grant (TIMEOUT = 0 disables this).
//
// Handshake semantics (both the req_* side and the par_* side): a word
// transfers on a rising clk edge where valid and ready are both high. The
// producer keeps valid, data and last stable while valid is high and ready
// is low; ready never depends on the same interface's valid.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   req_data    in  [R-1:0][N-1:0] requester words
//   req_valid   in  [R-1:0]        per-requester valid
//   req_last    in  [R-1:0]        final word of a packet, sampled with data
//   req_ready   out [R-1:0]        per-requester ready, at most one bit high
//   par_data    out [N-1:0]        registered word to p2s
//   par_valid   out                registered valid to p2s
//   par_ready   in                 p2s accepts par_data
//   grant_id    out [GID_W-1:0]    current or most recent grantee
//   busy        out                LOCKED or a word still waiting in par_*
//   abort       out                one-cycle pulse after a timeout revoke
//   words_sent  out [15:0]         par handshakes since reset, wrapping
//   dbg_state   out                FSM state, for observation only
// ----------------------------------------------------------------------------
module p2s_arbiter
    import p2s_arb_pkg::*;
#(
    parameter int  N       = 4,
    parameter int  R       = 3,
    parameter int  TIMEOUT = 16,
    localparam int GID_W   = gid_w(R)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [R-1:0][N-1:0]   req_data,
    input  logic [R-1:0]          req_valid,
    input  logic [R-1:0]          req_last,
    output logic [R-1:0]          req_ready,
    output logic [N-1:0]          par_data,
    output logic                  par_valid,
    input  logic                  par_ready,
    output logic [GID_W-1:0]      grant_id,
    output logic                  busy,
    output logic                  abort,
    output logic [CNT_W-1:0]      words_sent,
    output arb_state_t            dbg_state
);

    // Value the idle counter holds on the last tolerated quiet cycle; a
    // further quiet cycle at this value is the TIMEOUT-th one and revokes.
    localparam logic [CNT_W-1:0] TO_LIMIT =
        (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t        state_q, state_d;
    logic [GID_W-1:0]  ptr_q, ptr_d;
    logic [GID_W-1:0]  gid_q, gid_d;
    logic [R-1:0]      gnt_oh_q, gnt_oh_d;
    logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
    logic [N-1:0]      out_data_q;
    logic              out_valid_q;
    logic              abort_q;
    logic [CNT_W-1:0]  words_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [R-1:0]      arb_gnt;
    logic [GID_W-1:0]  arb_idx;
    logic              arb_any;

    logic [N-1:0]      sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              slot_free;
    logic              accept;
    logic              expire;
    logic [GID_W-1:0]  next_ptr;

    rr_arbiter #(
        .R (R)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_gnt),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // The grantee's signals, picked with the held one-hot grant (AND-OR).
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < R; i++) begin
            if (gnt_oh_q[i]) begin
                sel_data  = sel_data | req_data[i];
                sel_valid = sel_valid | req_valid[i];
                sel_last  = sel_last | req_last[i];
            end
        end
    end

    // The output register can take a word when empty or draining this cycle.
    assign slot_free = !out_valid_q || par_ready;

    // Priority moves to the requester after the one just served.
    assign next_ptr = (gid_q == GID_W'(R - 1)) ? '0 : gid_q + 1'b1;

    // ------------------------------------------------------------------
    // FSM next-state and req_ready
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        gnt_oh_d  = gnt_oh_q;
        to_cnt_d  = to_cnt_q;
        req_ready = '0;
        accept    = 1'b0;
        expire    = 1'b0;

        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (arb_any) begin
                    state_d  = LOCKED;
                    gid_d    = arb_idx;
                    gnt_oh_d = arb_gnt;
                end
            end

            LOCKED: begin
                // Depends only on held grant, output register and par_ready.
                if (slot_free) begin
                    req_ready = gnt_oh_q;
                end
                accept = sel_valid && slot_free;

                if (sel_valid) begin
                    to_cnt_d = '0;
                end else if (TIMEOUT != 0) begin
                    if (to_cnt_q == TO_LIMIT) begin
                        expire = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end

                // Expiry needs sel_valid low and acceptance needs it high,
                // so these two never both fire.
                if ((accept && sel_last) || expire) begin
                    state_d  = IDLE;
                    ptr_d    = next_ptr;
                    to_cnt_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gid_q       <= '0;
            gnt_oh_q    <= '0;
            to_cnt_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gid_q    <= gid_d;
            gnt_oh_q <= gnt_oh_d;
            to_cnt_q <= to_cnt_d;
            abort_q  <= expire;

            // A load wins over a drain in the same cycle; data only changes
            // on a load, so it stays put while stalled.
            if (accept) begin
                out_data_q  <= sel_data;
                out_valid_q <= 1'b1;
            end else if (par_ready) begin
                out_valid_q <= 1'b0;
            end

            if (out_valid_q && par_ready) begin
                words_q <= words_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign par_data   = out_data_q;
    assign par_valid  = out_valid_q;
    assign grant_id   = gid_q;
    assign busy       = (state_q == LOCKED) || out_valid_q;
    assign abort      = abort_q;
    assign words_sent = words_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_p2s_arbiter.sv
// ----------------------------------------------------------------------------
// tb_p2s_arbiter
//
// Bench for p2s_arbiter with N=4, R=3, TIMEOUT=4 and the serializer side
// driven directly through par_ready. Requester drivers pull words from
// per-requester queues; exp_q holds the order in which words must be
// accepted, pipe_q the words that must then appear on par_data.
// ----------------------------------------------------------------------------
module tb_p2s_arbiter;
    import p2s_arb_pkg::*;

    localparam int N       = 4;
    localparam int R       = 3;
    localparam int TIMEOUT = 4;
    localparam int GW      = 2;
    localparam int W       = GW + N;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [R-1:0][N-1:0] req_data;
    logic [R-1:0]        req_valid;
    logic [R-1:0]        req_last;
    logic [R-1:0]        req_ready;
    logic [N-1:0]        par_data;
    logic                par_valid;
    logic                par_ready;
    logic [GW-1:0]       grant_id;
    logic                busy;
    logic                abort;
    logic [15:0]         words_sent;
    arb_state_t          dbg_state;

    p2s_arbiter #(
        .N       (N),
        .R       (R),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .par_data   (par_data),
        .par_valid  (par_valid),
        .par_ready  (par_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .abort      (abort),
        .words_sent (words_sent),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];      // {requester, data} in acceptance order
    logic [N-1:0] pipe_q[$];     // accepted words still to reach par_data
    logic [N:0]   drv0_q[$];     // {last, data} per requester
    logic [N:0]   drv1_q[$];
    logic [N:0]   drv2_q[$];
    int           acc_cyc[$];    // cycle number of every acceptance
    int           cyc       = 0;
    int           abort_cnt = 0;
    int           ws_exp    = 0;
    logic [R-1:0] fire      = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Queue one word for requester r and record where it must be accepted.
    task automatic push_word(input int r, input logic last, input logic [N-1:0] data);
        case (r)
            0:       drv0_q.push_back({last, data});
            1:       drv1_q.push_back({last, data});
            default: drv2_q.push_back({last, data});
        endcase
        exp_q.push_back({GW'(r), data});
        ws_exp++;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        ws_exp = 0;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},      dbg_state,  IDLE);
        check({tag, "_par_valid"},  par_valid,  0);
        check({tag, "_par_data"},   par_data,   0);
        check({tag, "_req_ready"},  req_ready,  0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_abort"},      abort,      0);
        check({tag, "_words_sent"}, words_sent, 0);
        check({tag, "_grant_id"},   grant_id,   0);
    endtask

    // Bounded wait for everything queued to be accepted and drained.
    task automatic wait_drain(input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && pipe_q.size() == 0 && !busy &&
                drv0_q.size() == 0 && drv1_q.size() == 0 && drv2_q.size() == 0)
                break;
        end
        if (k == 200)
            check({tag, "_drain_timeout"}, exp_q.size() + pipe_q.size(), 0);
        check({tag, "_words_sent"}, words_sent, ws_exp);
    endtask

    // ---------------- requester drivers ----------------
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                drv0_q.delete();
                drv1_q.delete();
                drv2_q.delete();
            end else begin
                if (fire[0]) drv0_q.delete(0);
                if (fire[1]) drv1_q.delete(0);
                if (fire[2]) drv2_q.delete(0);
            end
            req_valid[0] = (drv0_q.size() != 0);
            req_valid[1] = (drv1_q.size() != 0);
            req_valid[2] = (drv2_q.size() != 0);
            {req_last[0], req_data[0]} = (drv0_q.size() != 0) ? drv0_q[0] : '0;
            {req_last[1], req_data[1]} = (drv1_q.size() != 0) ? drv1_q[0] : '0;
            {req_last[2], req_data[2]} = (drv2_q.size() != 0) ? drv2_q[0] : '0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] got;
        logic [R-1:0] prev_stall;
        logic [R-1:0][N-1:0] prev_data;
        logic [R-1:0] prev_last;
        prev_stall = '0;
        prev_data  = '0;
        prev_last  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                fire = '0;
                prev_stall = '0;
                exp_q.delete();
                pipe_q.delete();
                acc_cyc.delete();
            end else begin
                if (abort) abort_cnt++;
                for (int r = 0; r < R; r++) begin
                    if (prev_stall[r])
                        assert (req_valid[r] && req_data[r] == prev_data[r] &&
                                req_last[r] == prev_last[r])
                        else $error("requester %0d broke valid/ready hold", r);
                end
                // Drain before load: par_data shows the older word.
                if (par_valid && par_ready) begin
                    if (pipe_q.size() == 0)
                        check("drain_has_word", pipe_q.size(), 1);
                    else
                        check("par_data", par_data, pipe_q.pop_front());
                end
                fire = req_valid & req_ready;
                for (int r = 0; r < R; r++) begin
                    if (fire[r]) begin
                        got = {GW'(r), req_data[r]};
                        if (exp_q.size() == 0)
                            check("accept_expected", exp_q.size(), 1);
                        else
                            check("accept_id_data", got, exp_q.pop_front());
                        pipe_q.push_back(req_data[r]);
                        acc_cyc.push_back(cyc);
                    end
                end
                prev_stall = req_valid & ~req_ready;
                prev_data  = req_data;
                prev_last  = req_last;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        int k;
        par_ready = 1'b1;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_reset_values("por");

        // Single word: req0 sends 1010 with last; valid in cycle t.
        push_word(0, 1'b1, 4'b1010);
        @(negedge clk);                        // cycle t
        check("sw_t_state", dbg_state, IDLE);
        check("sw_t_ready", req_ready, 3'b000);
        @(negedge clk);                        // t+1
        check("sw_t1_state", dbg_state, LOCKED);
        check("sw_t1_ready", req_ready, 3'b001);
        check("sw_t1_par_valid", par_valid, 0);
        @(negedge clk);                        // t+2
        check("sw_t2_par_valid", par_valid, 1);
        check("sw_t2_par_data", par_data, 4'b1010);
        check("sw_t2_grant_id", grant_id, 0);
        check("sw_t2_state", dbg_state, IDLE);
        @(negedge clk);                        // t+3
        check("sw_t3_words", words_sent, 1);
        check("sw_t3_par_valid", par_valid, 0);
        wait_drain("sw");

        // Fairness from reset: grants 0,1,2,0, one bubble between packets.
        do_reset();
        push_word(0, 1'b1, 4'h3);
        push_word(1, 1'b1, 4'h5);
        push_word(2, 1'b1, 4'h9);
        push_word(0, 1'b1, 4'hE);
        wait_drain("fair");
        check("fair_count", acc_cyc.size(), 4);
        for (int i = 1; i < 4 && i < acc_cyc.size(); i++)
            check("fair_gap", acc_cyc[i] - acc_cyc[i-1], 2);

        // Packet lock: ptr now at 1, req1 PIN 3,7,1,9 beats waiting req0.
        acc_cyc.delete();
        push_word(1, 1'b0, 4'd3);
        push_word(1, 1'b0, 4'd7);
        push_word(1, 1'b0, 4'd1);
        push_word(1, 1'b1, 4'd9);
        push_word(0, 1'b1, 4'hA);
        wait_drain("lock");
        check("lock_count", acc_cyc.size(), 5);
        for (int i = 1; i < 5 && i < acc_cyc.size(); i++)
            check("lock_gap", acc_cyc[i] - acc_cyc[i-1], (i == 4) ? 2 : 1);

        // Backpressure: par_ready low for 6 cycles with a word held.
        @(posedge clk); #2;
        par_ready = 1'b0;
        @(negedge clk);
        push_word(2, 1'b0, 4'd5);
        push_word(2, 1'b0, 4'd6);
        push_word(2, 1'b1, 4'd7);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (par_valid) break;
        end
        check("bp_par_valid_seen", par_valid, 1);
        for (int i = 0; i < 6; i++) begin
            check("bp_hold_valid", par_valid, 1);
            check("bp_hold_data", par_data, 4'd5);
            check("bp_ready_low", req_ready, 3'b000);
            if (i < 5) @(negedge clk);
        end
        @(posedge clk); #2;
        par_ready = 1'b1;
        wait_drain("bp");

        // Timeout: req2 sends 0001 without last, then goes quiet.
        acc_cyc.delete();
        abort_cnt = 0;
        push_word(2, 1'b0, 4'b0001);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (acc_cyc.size() != 0) break;
        end
        check("to_accepted", acc_cyc.size(), 1);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 2) push_word(0, 1'b1, 4'hC);
            check("to_abort", abort, (j == 5));
            if (j < 5) check("to_state_locked", dbg_state, LOCKED);
            if (j == 5) check("to_state_idle", dbg_state, IDLE);
            if (j == 6) begin
                check("to_next_ready", req_ready, 3'b001);
                check("to_next_gid", grant_id, 0);
            end
        end
        wait_drain("to");
        check("to_abort_pulses", abort_cnt, 1);

        // Mid-packet reset while par_valid is high.
        push_word(1, 1'b0, 4'd1);
        push_word(1, 1'b0, 4'd2);
        push_word(1, 1'b1, 4'd3);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (par_valid) break;
        end
        check("mr_par_valid_seen", par_valid, 1);
        do_reset();
        check_reset_values("mr");

        // After reset ptr is 0 again: req0 wins over req1.
        push_word(0, 1'b1, 4'h4);
        push_word(1, 1'b1, 4'h8);
        wait_drain("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
